// File: rtl/pipe_sel_mux.sv
// pipe_sel_mux: N-way, W-bit registered select multiplexer with a valid/ready
// handshake and a one-word skid register. Illegal select codes are consumed,
// dropped and counted.
//
// Handshake: a word moves on a rising edge when valid and ready are both high
// on that side (in_valid & in_ready on input, out_valid & out_ready on output).
// A producer that raises valid holds its payload until the transfer happens.
// out_data/out_sel never change while out_valid & !out_ready. in_ready is
// purely a function of registered state (it is low only when the skid register
// is occupied), so it never depends on out_ready in the same cycle.
module pipe_sel_mux #(
  parameter int WIDTH     = 32,
  parameter int NUM_IN    = 3,
  parameter int ERR_CNT_W = 8,
  localparam int SEL_W    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  output logic [ERR_CNT_W-1:0]    err_count,
  output logic [1:0]              dbg_state
);

  // Occupancy states: nothing held, main register only, main plus skid.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] main_data;
  logic [SEL_W-1:0] main_sel;
  logic [WIDTH-1:0] skid_data;
  logic [SEL_W-1:0] skid_sel;

  logic [SEL_W-1:0] eff_sel;
  logic [31:0]      sel_ext;
  logic             legal;
  logic             accept;
  logic             push;
  logic             drain;
  logic [WIDTH-1:0] mux_data;

  // With a single input the select code carries no information; force it to 0.
  assign eff_sel = (NUM_IN == 1) ? '0 : in_sel;
  assign sel_ext = 32'(eff_sel);
  assign legal   = (sel_ext < 32'(NUM_IN));

  assign in_ready  = (state != ST_TWO);
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_data;
  assign out_sel   = main_sel;
  assign dbg_state = state;

  assign accept = in_valid & in_ready;
  assign push   = accept & legal;
  assign drain  = out_valid & out_ready;

  // Select the addressed input; an out-of-range code yields zero, never X.
  always_comb begin
    mux_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel_ext == 32'(k)) begin
        mux_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Occupancy FSM with main/skid data movement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      main_data <= '0;
      main_sel  <= '0;
      skid_data <= '0;
      skid_sel  <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            main_data <= mux_data;
            main_sel  <= eff_sel;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && drain) begin
            main_data <= mux_data;
            main_sel  <= eff_sel;
          end else if (push) begin
            skid_data <= mux_data;
            skid_sel  <= eff_sel;
            state     <= ST_TWO;
          end else if (drain) begin
            state     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drain) begin
            main_data <= skid_data;
            main_sel  <= skid_sel;
            state     <= ST_ONE;
          end
        end
        default: begin
          state <= ST_EMPTY;
        end
      endcase
    end
  end

  // Illegal-select pulse and saturating counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err   <= 1'b0;
      err_count <= '0;
    end else begin
      sel_err <= accept & ~legal;
      if (accept && !legal && (err_count != {ERR_CNT_W{1'b1}})) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule
